pc_sequencer: RTL

//  Fetch-side program-counter controller for the 8-bit core. Owns the PC register, sequences

---
 rtl/pc_ctrl_pkg.sv | 19 +
 rtl/Branch_Target_Calculator.sv | 15 +
 rtl/pc_sequencer.sv | 109 ++++++++++
 3 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared types and default parameters for the fetch-side PC controller.
// Imported by the PC sequencer and its testbench.
package pc_ctrl_pkg;

    localparam int PC_W         = 8;
    localparam int IMM_W        = 16;
    localparam int FLUSH_CYCLES = 2;

    typedef logic [PC_W-1:0] pc_t;

    localparam pc_t RESET_PC = 8'h00;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        FLUSH = 2'b01,
        HALT  = 2'b10
    } pc_state_t;

endpackage

// File: rtl/Branch_Target_Calculator.sv
// Branch target adder: program counter plus sign-extended immediate,
// wrapped to the PC width.
module Branch_Target_Calculator #(
    parameter int PC_W  = 8,
    parameter int IMM_W = 16
) (
    input  logic [IMM_W-1:0] immediate,
    input  logic [PC_W-1:0]  program_counter,
    output logic [PC_W-1:0]  BT
);

    // Sign-extend or truncate the immediate to PC width, then add modulo 2^PC_W
    assign BT = program_counter + PC_W'($signed(immediate));

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter controller: increment, stall, redirect with flush
// bubbles, halt, and a saturating count of taken redirects.
module pc_sequencer #(
    parameter int              PC_W         = pc_ctrl_pkg::PC_W,
    parameter int              IMM_W        = pc_ctrl_pkg::IMM_W,
    parameter logic [PC_W-1:0] RESET_PC     = pc_ctrl_pkg::RESET_PC,
    parameter int              FLUSH_CYCLES = pc_ctrl_pkg::FLUSH_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch_valid,
    input  logic             branch_taken,
    input  logic [PC_W-1:0]  branch_pc,
    input  logic [IMM_W-1:0] branch_imm,
    input  logic             jump_valid,
    input  logic [PC_W-1:0]  jump_addr,
    input  logic             halt_req,
    output logic [PC_W-1:0]  pc,
    output logic             fetch_valid,
    output logic             flush,
    output logic             redirect,
    output logic [7:0]       taken_count
);

    import pc_ctrl_pkg::*;

    localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

    pc_state_t       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            redir_q, redir_d;
    logic [7:0]      taken_q, taken_d;
    logic [PC_W-1:0] bt;

    Branch_Target_Calculator #(
        .PC_W  (PC_W),
        .IMM_W (IMM_W)
    ) u_btc (
        .immediate       (branch_imm),
        .program_counter (branch_pc),
        .BT              (bt)
    );

    // Next-state, next-PC, flush counter and redirect counter
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        redir_d = 1'b0;
        taken_d = taken_q;
        unique case (state_q)
            RUN: begin
                if (branch_valid && branch_taken) begin
                    pc_d    = bt;
                    state_d = FLUSH;
                    cnt_d   = CNT_LOAD;
                    redir_d = 1'b1;
                    if (taken_q != 8'hFF) taken_d = taken_q + 8'd1;
                end else if (jump_valid) begin
                    pc_d    = jump_addr;
                    state_d = FLUSH;
                    cnt_d   = CNT_LOAD;
                    redir_d = 1'b1;
                    if (taken_q != 8'hFF) taken_d = taken_q + 8'd1;
                end else if (halt_req) begin
                    state_d = HALT;
                end else if (!stall) begin
                    pc_d = pc_q + 1'b1;
                end
            end
            FLUSH: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd0) state_d = RUN;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State and datapath registers, asynchronously reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            cnt_q   <= 3'd0;
            redir_q <= 1'b0;
            taken_q <= 8'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            redir_q <= redir_d;
            taken_q <= taken_d;
        end
    end

    assign pc          = pc_q;
    assign redirect    = redir_q;
    assign taken_count = taken_q;
    assign fetch_valid = (state_q == RUN);
    assign flush       = (state_q == FLUSH);

endmodule
